// File: rtl/mips_lsu_pkg.sv
// Shared memory-stage types for the MIPS load/store unit: access sizes, LSU states,
// the latched op descriptor and the byte-count helper.
package mips_mem_pkg;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} size_e;

  typedef enum logic {IDLE, WAIT} lsu_state_e;

  // Op attributes carried from accept to the ack edge
  typedef struct packed {
    logic  load;
    logic  sc;
    size_e size;
    logic  signext;
  } lsu_op_t;

  function automatic logic [3:0] size_bytes(size_e s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Memory-side req/ack bus of the load/store unit; the LSU is the master.
interface mips_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  localparam int NB = DATA_W / 8;

  logic              mem_req;
  logic [NB-1:0]     mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mips_lsu_align.sv
// Big-endian lane steering: write-lane mask, element replication and read
// extract with sign/zero extension. Expects an already aligned offset.
module mips_lsu_align
  import mips_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_e                  size,
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic                   signext,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W-1:0]      rdata,
  output logic [DATA_W/8-1:0]    lane_mask,
  output logic [DATA_W-1:0]      wdata_rep,
  output logic [DATA_W-1:0]      rdata_ext
);
  localparam int NB = DATA_W / 8;
  localparam int LG = $clog2(NB);

  logic [3:0]    nb;
  logic [LG-1:0] bse;  // lane holding the element's least significant byte
  logic [LG-1:0] msl;  // lane holding the element's most significant byte
  logic          sbit;

  assign nb   = size_bytes(size);
  assign bse  = LG'(4'(NB) - nb - 4'(off));
  assign msl  = LG'(4'(bse) + nb - 4'd1);
  assign sbit = signext & rdata[8*msl + 7];

  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic [LG-1:0] widx;
    logic [LG-1:0] ridx;
    assign widx = LG'(k) & LG'(nb - 4'd1);
    assign ridx = bse + LG'(k);
    assign lane_mask[k]      = (4'(k) >= 4'(bse)) && (4'(k) < 4'(bse) + nb);
    assign wdata_rep[8*k+:8] = wdata[8*widx +: 8];
    assign rdata_ext[8*k+:8] = (4'(k) < nb) ? rdata[8*ridx +: 8] : {8{sbit}};
  end

endmodule

// File: rtl/mips_lsu.sv
// MIPS memory-stage load/store unit with LL/SC reservation and req/ack bus.
// Define LSU_ALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning.
module mips_lsu
  import mips_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic                ex_load,
  input  logic                ex_store,
  input  logic [1:0]          ex_size,
  input  logic                ex_signext,
  input  logic                ex_ll,
  input  logic                ex_sc,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [RD_W-1:0]     ex_rd,
  output logic                lsu_stall,
  mips_lsu_if.master          mem,
  input  logic                snoop_valid,
  input  logic [ADDR_W-1:0]   snoop_addr,
  output logic                wb_valid,
  output logic [RD_W-1:0]     wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic                lsu_misalign
);
  localparam int NB    = DATA_W / 8;
  localparam int LG    = $clog2(NB);
  localparam int TAG_W = ADDR_W - LG;

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_WAIT = 1'(WAIT);

  logic [0:0]       state;
  lsu_op_t          r_op;
  logic [LG-1:0]    r_off;
  logic [RD_W-1:0]  r_rd;
  logic             resv_valid;
  logic [TAG_W-1:0] resv_tag;

  // ---------------- request decode ----------------
  size_e             ex_sz;
  logic [3:0]        ex_nb;
  logic [ADDR_W-1:0] low_mask;
  logic [ADDR_W-1:0] ex_addr_al;
  logic [LG-1:0]     ex_off;
  logic              is_ld, is_st, is_sc;
  logic              accept, trap;

  // A 32-bit bus has no doubleword: fold it onto word
  assign ex_sz      = (NB == 4 && ex_size == 2'd3) ? SZ_WORD : size_e'(ex_size);
  assign ex_nb      = size_bytes(ex_sz);
  assign low_mask   = ADDR_W'(ex_nb - 4'd1);
  assign ex_addr_al = ex_addr & ~low_mask;
  assign ex_off     = ex_addr_al[LG-1:0];

  assign is_ld  = ex_load;
  assign is_st  = ex_store & ~ex_load;
  assign is_sc  = is_st & ex_sc;
  assign accept = (state == ST_IDLE) & ex_valid & (ex_load | ex_store);

`ifdef LSU_ALIGN_TRAP_EN
  assign trap = |(ex_addr & low_mask);
`else
  assign trap = 1'b0;
`endif

  // ---------------- reservation ----------------
  logic [TAG_W-1:0] ex_tag, snoop_tag;
  logic             tag_hit, snoop_hit, sc_ok;
  logic             unused_snoop_lo;

  assign ex_tag          = ex_addr[ADDR_W-1:LG];
  assign snoop_tag       = snoop_addr[ADDR_W-1:LG];
  assign unused_snoop_lo = ^snoop_addr[LG-1:0];
  assign tag_hit         = resv_valid && (resv_tag == ex_tag);
  assign snoop_hit       = snoop_valid && resv_valid && (snoop_tag == resv_tag);
  // A snoop landing in the same cycle as the SC check wins
  assign sc_ok           = tag_hit & ~snoop_hit;

  // ---------------- lane steering ----------------
  logic [NB-1:0]     wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] unused_wr_ext;
  logic [NB-1:0]     unused_rd_mask;
  logic [DATA_W-1:0] unused_rd_rep;

  mips_lsu_align #(.DATA_W(DATA_W)) u_wr_align (
    .size      (ex_sz),
    .off       (ex_off),
    .signext   (1'b0),
    .wdata     (ex_wdata),
    .rdata     ('0),
    .lane_mask (wr_mask),
    .wdata_rep (wr_data),
    .rdata_ext (unused_wr_ext)
  );

  mips_lsu_align #(.DATA_W(DATA_W)) u_rd_align (
    .size      (r_op.size),
    .off       (r_off),
    .signext   (r_op.signext),
    .wdata     ('0),
    .rdata     (mem.mem_rdata),
    .lane_mask (unused_rd_mask),
    .wdata_rep (unused_rd_rep),
    .rdata_ext (rd_data)
  );

  assign lsu_stall = (state != ST_IDLE);

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      r_op          <= '0;
      r_off         <= '0;
      r_rd          <= '0;
      resv_valid    <= 1'b0;
      resv_tag      <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      lsu_misalign  <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      lsu_misalign <= accept & trap;
      if (snoop_hit) resv_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept && !trap) begin
            if (is_sc && !sc_ok) begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_data  <= '0;
            end else begin
              state         <= ST_WAIT;
              mem.mem_req   <= 1'b1;
              mem.mem_addr  <= ex_addr_al;
              mem.mem_we    <= is_st ? wr_mask : '0;
              mem.mem_wdata <= is_st ? wr_data : '0;
              r_op          <= '{load: is_ld, sc: is_sc, size: ex_sz, signext: ex_signext};
              r_off         <= ex_off;
              r_rd          <= ex_rd;
              if (is_st && tag_hit) resv_valid <= 1'b0;
              if (is_ld && ex_ll) begin
                resv_valid <= 1'b1;
                resv_tag   <= ex_tag;
              end
            end
          end
        end
        ST_WAIT: begin
          if (mem.mem_ack) begin
            state       <= ST_IDLE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= '0;
            if (r_op.load) begin
              wb_valid <= 1'b1;
              wb_rd    <= r_rd;
              wb_data  <= rd_data;
            end else if (r_op.sc) begin
              wb_valid <= 1'b1;
              wb_rd    <= r_rd;
              wb_data  <= DATA_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu (DATA_W=32): directed table, LL/SC and reset
// corner sequences, then random ops checked against a byte-addressed reference model.
module tb_mips_lsu;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NB = DW / 8;
  localparam int LGB = 2;
`ifdef LSU_ALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 0, ex_load = 0, ex_store = 0, ex_signext = 0, ex_ll = 0, ex_sc = 0;
  logic [1:0]    ex_size = 0;
  logic [AW-1:0] ex_addr = 0;
  logic [DW-1:0] ex_wdata = 0;
  logic [4:0]    ex_rd = 0;
  logic          lsu_stall;
  logic          snoop_valid = 0;
  logic [AW-1:0] snoop_addr = 0;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          lsu_misalign;

  mips_lsu_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

  mips_lsu #(.DATA_W(DW), .ADDR_W(AW), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_size(ex_size), .ex_signext(ex_signext), .ex_ll(ex_ll), .ex_sc(ex_sc),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .lsu_stall(lsu_stall),
    .mem(mem_bus), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .lsu_misalign(lsu_misalign)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  typedef struct packed {
    bit          req;
    bit          mis;
    bit          wb;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wbd;
    logic [4:0]  wbrd;
  } res_t;

  typedef struct {
    bit          ld;
    bit          st;
    logic [1:0]  sz;
    bit          sx;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdv;
    int          dly;
    logic [3:0]  e_we;
    logic [31:0] e_val;  // expected mem_wdata for stores, wb_data for loads
  } vec_t;

  // reference reservation state
  bit          m_resv = 0;
  logic [29:0] m_tag = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory seen as bytes in address order; lane NB-1 holds the lowest address.
  task automatic model(input bit ld, st, input logic [1:0] sz, input bit sx, ll, sc,
                       input logic [31:0] addr, wd, rdv, input logic [4:0] rd,
                       input bit snp, input logic [31:0] saddr, output res_t e);
    int n, off;
    logic [63:0] v, el, rep;
    e = '0;
    n = (sz == 2'd3) ? 4 : (1 << sz);
    off = (addr - (addr % n)) % NB;
    if (snp && m_resv && (saddr >> LGB) == m_tag) m_resv = 0;
    if (TRAP && (addr % n) != 0) begin
      e.mis = 1;
      return;
    end
    if (st && sc && !(m_resv && (addr >> LGB) == m_tag)) begin
      e.wb = 1; e.wbd = 0; e.wbrd = rd;
      return;
    end
    e.req = 1;
    e.addr = addr - (addr % n);
    if (st) begin
      el = wd & ((64'h1 << (8*n)) - 1);
      rep = 0;
      for (int j = 0; j < NB / n; j++) rep = (rep << (8*n)) | el;
      e.wdata = rep[31:0];
      for (int i = 0; i < n; i++) e.we[NB-1-off-i] = 1'b1;
      if (m_resv && (addr >> LGB) == m_tag) m_resv = 0;
      if (sc) begin e.wb = 1; e.wbd = 1; e.wbrd = rd; end
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | ((rdv >> (8*(NB-1-(off+i)))) & 32'hFF);
      if (sx && n < NB && ((v >> (8*n-1)) & 1) != 0) v = v | (~64'h0 << (8*n));
      e.wb = 1; e.wbd = v[31:0]; e.wbrd = rd;
      if (ll) begin m_resv = 1; m_tag = addr >> LGB; end
    end
  endtask

  task automatic exec(input bit ld, st, input logic [1:0] sz, input bit sx, ll, sc,
                      input logic [31:0] addr, wd, rdv, input int dly,
                      input bit snp, input logic [31:0] saddr, output res_t r);
    res_t e;
    logic [4:0] rd;
    rd = 5'($urandom_range(1, 31));
    model(ld, st, sz, sx, ll, sc, addr, wd, rdv, rd, snp, saddr, e);
    ex_valid = 1; ex_load = ld; ex_store = st; ex_size = sz; ex_signext = sx;
    ex_ll = ll; ex_sc = sc; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    snoop_valid = snp; snoop_addr = saddr;
    @(posedge clk); #1;
    ex_valid = 0; ex_load = 0; ex_store = 0; ex_ll = 0; ex_sc = 0; snoop_valid = 0;
    r = '0;
    r.req = mem_bus.mem_req; r.mis = lsu_misalign; r.we = mem_bus.mem_we;
    r.addr = mem_bus.mem_addr; r.wdata = mem_bus.mem_wdata;
    r.wb = wb_valid; r.wbd = wb_data; r.wbrd = wb_rd;
    chk("req", 32'(r.req), 32'(e.req));
    chk("stall", 32'(lsu_stall), 32'(e.req));
    chk("misalign", 32'(r.mis), 32'(e.mis));
    if (e.req) begin
      chk("addr", r.addr, e.addr);
      chk("we", 32'(r.we), 32'(e.we));
      if (st) chk("wdata", r.wdata, e.wdata);
      chk("early_wb", 32'(wb_valid), 0);
      repeat (dly) begin
        @(posedge clk); #1;
        chk("hold_req", 32'(mem_bus.mem_req), 1);
        chk("hold_addr", mem_bus.mem_addr, e.addr);
      end
      mem_bus.mem_ack = 1; mem_bus.mem_rdata = rdv;
      @(posedge clk); #1;
      mem_bus.mem_ack = 0; mem_bus.mem_rdata = $urandom;
      r.wb = wb_valid; r.wbd = wb_data; r.wbrd = wb_rd;
      chk("post_stall", 32'(lsu_stall), 0);
      chk("post_req", 32'(mem_bus.mem_req), 0);
    end
    chk("wb_valid", 32'(r.wb), 32'(e.wb));
    if (e.wb) begin
      chk("wb_data", r.wbd, e.wbd);
      chk("wb_rd", 32'(r.wbrd), 32'(e.wbrd));
    end
    @(posedge clk); #1;
    chk("wb_pulse", 32'(wb_valid), 0);
  endtask

  task automatic snoop_cycle(input logic [31:0] a);
    snoop_valid = 1; snoop_addr = a;
    @(posedge clk); #1;
    snoop_valid = 0;
    if (m_resv && (a >> LGB) == m_tag) m_resv = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    res_t r;
    mem_bus.mem_ack = 0;
    mem_bus.mem_rdata = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_bus.mem_req), 0);
    chk("rst_we", 32'(mem_bus.mem_we), 0);
    chk("rst_stall", 32'(lsu_stall), 0);
    chk("rst_wb", 32'(wb_valid), 0);
    chk("rst_wbd", wb_data, 0);
    chk("rst_mis", 32'(lsu_misalign), 0);
    rst = 0;

    // ack while idle is ignored
    mem_bus.mem_ack = 1;
    @(posedge clk); #1;
    mem_bus.mem_ack = 0;
    @(posedge clk); #1;
    chk("idle_ack_wb", 32'(wb_valid), 0);
    chk("idle_ack_stall", 32'(lsu_stall), 0);

    //             ld st sz   sx  addr          wd            rdv           dly we     val
    tbl.push_back('{1, 0, 2'd0, 1, 32'h1003, 32'h0,        32'h123456F0, 0, 4'h0, 32'hFFFFFFF0});
    tbl.push_back('{0, 1, 2'd1, 0, 32'h2002, 32'h0000BEEF, 32'h0,        2, 4'h3, 32'hBEEFBEEF});
    tbl.push_back('{1, 0, 2'd0, 0, 32'h1000, 32'h0,        32'h9A345678, 1, 4'h0, 32'h0000009A});
    tbl.push_back('{1, 0, 2'd0, 1, 32'h1001, 32'h0,        32'h12F45678, 0, 4'h0, 32'hFFFFFFF4});
    tbl.push_back('{1, 0, 2'd1, 0, 32'h1000, 32'h0,        32'h80012345, 3, 4'h0, 32'h00008001});
    tbl.push_back('{1, 0, 2'd1, 1, 32'h1002, 32'h0,        32'h12348765, 0, 4'h0, 32'hFFFF8765});
    tbl.push_back('{1, 0, 2'd2, 1, 32'h1004, 32'h0,        32'hDEADBEEF, 1, 4'h0, 32'hDEADBEEF});
    tbl.push_back('{0, 1, 2'd0, 0, 32'h2001, 32'hFFFFFFAB, 32'h0,        0, 4'h4, 32'hABABABAB});
    tbl.push_back('{0, 1, 2'd2, 0, 32'h2008, 32'h01020304, 32'h0,        1, 4'hF, 32'h01020304});
    tbl.push_back('{0, 1, 2'd0, 0, 32'h2003, 32'h0000005A, 32'h0,        0, 4'h1, 32'h5A5A5A5A});
    tbl.push_back('{1, 0, 2'd3, 1, 32'h100C, 32'h0,        32'hCAFEF00D, 2, 4'h0, 32'hCAFEF00D});
    tbl.push_back('{0, 1, 2'd1, 0, 32'h2000, 32'h00001234, 32'h0,        0, 4'hC, 32'h12341234});
    foreach (tbl[i]) begin
      exec(tbl[i].ld, tbl[i].st, tbl[i].sz, tbl[i].sx, 0, 0, tbl[i].addr, tbl[i].wd,
           tbl[i].rdv, tbl[i].dly, 0, 0, r);
      chk("tbl_we", 32'(r.we), 32'(tbl[i].e_we));
      if (tbl[i].st) begin
        chk("tbl_wdata", r.wdata, tbl[i].e_val);
        chk("tbl_store_nowb", 32'(r.wb), 0);
      end else begin
        chk("tbl_wbd", r.wbd, tbl[i].e_val);
      end
    end

    // LL then SC succeeds, second SC fails without a request
    exec(1, 0, 2'd2, 0, 1, 0, 32'h3000, 0, 32'h11223344, 0, 0, 0, r);
    exec(0, 1, 2'd2, 0, 0, 1, 32'h3000, 32'd7, 0, 1, 0, 0, r);
    chk("sc1_req", 32'(r.req), 1);
    chk("sc1_we", 32'(r.we), 32'hF);
    chk("sc1_wbd", r.wbd, 1);
    exec(0, 1, 2'd2, 0, 0, 1, 32'h3000, 32'd7, 0, 0, 0, 0, r);
    chk("sc2_req", 32'(r.req), 0);
    chk("sc2_wb", 32'(r.wb), 1);
    chk("sc2_wbd", r.wbd, 0);

    // snoop in an earlier cycle kills the reservation
    exec(1, 0, 2'd2, 0, 1, 0, 32'h4000, 0, 32'h0, 0, 0, 0, r);
    snoop_cycle(32'h4002);
    exec(0, 1, 2'd2, 0, 0, 1, 32'h4000, 32'd9, 0, 0, 0, 0, r);
    chk("snp_sc_req", 32'(r.req), 0);
    chk("snp_sc_wbd", r.wbd, 0);

    // snoop in the same cycle as the SC check wins
    exec(1, 0, 2'd2, 0, 1, 0, 32'h4100, 0, 32'h0, 0, 0, 0, r);
    exec(0, 1, 2'd2, 0, 0, 1, 32'h4100, 32'd9, 0, 0, 1, 32'h4101, r);
    chk("snp_same_req", 32'(r.req), 0);
    chk("snp_same_wb", 32'(r.wb), 1);

    // reset while waiting; the late ack must be ignored
    ex_valid = 1; ex_load = 1; ex_size = 2'd2; ex_addr = 32'h5000; ex_rd = 5'd3;
    @(posedge clk); #1;
    ex_valid = 0; ex_load = 0;
    chk("rw_req", 32'(mem_bus.mem_req), 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m_resv = 0;
    chk("rw_req_clr", 32'(mem_bus.mem_req), 0);
    chk("rw_stall_clr", 32'(lsu_stall), 0);
    @(posedge clk); #1;
    mem_bus.mem_ack = 1;
    @(posedge clk); #1;
    mem_bus.mem_ack = 0;
    chk("rw_late_wb0", 32'(wb_valid), 0);
    @(posedge clk); #1;
    chk("rw_late_wb1", 32'(wb_valid), 0);

    // misaligned word
    exec(1, 0, 2'd2, 0, 0, 0, 32'h6002, 0, 32'hA5A55A5A, 0, 0, 0, r);
`ifdef LSU_ALIGN_TRAP_EN
    chk("mis_pulse", 32'(r.mis), 1);
    chk("mis_noreq", 32'(r.req), 0);
`else
    chk("mis_addr", r.addr, 32'h6000);
    chk("mis_wbd", r.wbd, 32'hA5A55A5A);
`endif

    // randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      int t;
      logic [31:0] a, sa;
      t  = $urandom_range(0, 3);
      a  = 32'h7000 | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      sa = 32'h7000 | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      exec(t == 0 || t == 2, t == 1 || t == 3, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           t == 2, t == 3, a, $urandom, $urandom, $urandom_range(0, 3),
           $urandom_range(0, 3) == 0, sa, r);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Parametrised load/store unit for the MIPS pipeline memory stage.
- Handles byte, half, word and (when DATA_W=64) doubleword accesses with big-endian lane selection, sign/zero extension and write-lane masks.
- Adds LL/SC reservation tracking and a variable-latency req/ack memory handshake.
- Raises a stall to the pipeline while a transaction is in flight.

Parameters:
- DATA_W, 32, memory data width in bits; legal values 32 or 64. NB = DATA_W/8 byte lanes.
- ADDR_W, 32, address width in bits.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  memory op presented this cycle
- ex_load  in  1  op is a load (LB/LH/LW/LL/LD)
- ex_store  in  1  op is a store (SB/SH/SW/SC/SD)
- ex_size  in  2  0=byte, 1=half, 2=word, 3=dword
- ex_signext  in  1  sign-extend load result
- ex_ll  in  1  load-linked
- ex_sc  in  1  store-conditional
- ex_addr  in  ADDR_W  effective byte address
- ex_wdata  in  DATA_W  store data, right-justified
- ex_rd  in  RD_W  destination register
- lsu_stall  out  1  unit busy; pipeline must hold
- mem_req  out  1  memory request, held until ack
- mem_we  out  NB  byte-lane write enables; bit k covers bits [8k+7:8k]; all zero means read
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_ack  in  1  request complete; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  read data
- snoop_valid  in  1  external write observed
- snoop_addr  in  ADDR_W  external write address
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  RD_W  writeback register
- wb_data  out  DATA_W  writeback data
- lsu_misalign  out  1  one-cycle misalignment pulse

Behaviour:
- Reset: all outputs 0, state IDLE, reservation invalid.
- States:
  - IDLE: ex_valid & (ex_load|ex_store) accepted only in IDLE.
  - WAIT: mem_req=1, outputs held stable.
  - IDLE is re-entered on the mem_ack edge.
- lsu_stall = (state != IDLE). Ops presented while stalled are ignored; the pipeline guarantees they are held.
- Latency:
  - Accept at cycle T; mem_req first high at T+1.
  - Earliest ack at T+1; wb_valid pulses the cycle after ack.
  - Minimum load-to-writeback latency is 2 cycles.
- Stores (except SC) produce no wb_valid.
- Lane mapping is big-endian: byte offset o maps to lane NB-1-o.
  - Half: lanes {NB-1-o, NB-2-o}.
  - Word on DATA_W=64: offset 0 maps to the upper four lanes.
- mem_wdata: element replicated across all lanes of its size.
- Load result: selected lanes right-justified; sign-extended if ex_signext, else zero-extended. Word and dword are unmodified when they fill DATA_W.
- ex_size=3 with DATA_W=32 is treated as word.
- Alignment: an access is misaligned when addr mod size_bytes != 0.
- LL/SC:
  - LL sets reservation valid and records addr[ADDR_W-1:log2(NB)].
  - SC succeeds when the reservation is valid and the tag matches. On success: store issued, reservation cleared, wb_data=1 after ack.
  - SC failure: no memory request, no stall, wb_valid at T+1 with wb_data=0.
  - The reservation clears on: any own store to the reserved tag; snoop_valid with matching tag (including the same cycle as an SC check, where the snoop wins and the SC fails); rst.
- mem_ack while IDLE is ignored.
- rst asserted in WAIT: state IDLE and mem_req=0 at the next edge; a late ack is ignored and no wb_valid is produced.
- Accept and ack never coincide, since accept requires IDLE.

Optional Feature:
- Macro: LSU_ALIGN_TRAP_EN.
- Defined: a misaligned access is not issued; lsu_misalign pulses at T+1; no wb_valid; the reservation is unchanged.
- Undefined: the address is force-aligned by clearing the low log2(size_bytes) bits and the access proceeds; lsu_misalign is tied 0.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD.
  - LSU state enum: IDLE, WAIT.
  - function size_bytes(size).
- One sub-module, mips_lsu_align: combinational lane-mask, write replication and read extract/extend. It is instantiated once each for the write path and the read path.

Test Plan:
- DATA_W=32, LB at addr 0x1003, signext=1, mem_rdata=0x123456F0, ack at T+1 -> wb_valid at T+2, wb_data=0xFFFFFFF0; mem_we=0000.
- SH at addr 0x2002, wdata=0x0000BEEF -> mem_we=0011, mem_wdata=0xBEEFBEEF; no wb_valid; lsu_stall high T+1 until the ack edge.
- LL at 0x3000, then SC at 0x3000 with wdata=7 -> store issued with mem_we=1111, wb_data=1; a second SC at 0x3000 -> no mem_req, wb_valid at T+1, wb_data=0.
- LL at 0x4000; snoop_valid with snoop_addr=0x4002; SC at 0x4000 -> SC fails, wb_data=0.
- LW at 0x5000; ack withheld 5 cycles; rst pulsed in cycle 3 -> mem_req=0 next edge, late ack ignored, no wb_valid.
- LW at 0x6002: with LSU_ALIGN_TRAP_EN -> lsu_misalign pulse, no mem_req; without it -> mem_addr=0x6000, normal load.
